// File: rtl/cam_frame_writer.sv
// Camera capture stage: samples the sensor bus, packs RGB565 byte pairs into RGB444 pixels and
// issues frame-buffer writes for an H_PIX x V_LINES frame. Define GRAYSCALE_EN for luma output.
module cam_frame_writer #(
    parameter int unsigned H_PIX   = 320,
    parameter int unsigned V_LINES = 240,
    parameter int unsigned ADDR_W  = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_en,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_wAddr,
    output logic [11:0]       fb_wData,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned PIX_W  = $clog2(H_PIX + 1);
    localparam int unsigned LINE_W = $clog2(V_LINES + 1);
    localparam logic [PIX_W-1:0]  PIX_MAX   = PIX_W'(H_PIX);
    localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(V_LINES);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_ACTIVE
    } state_t;

    state_t state;

    logic              vs_q, vs_qq;
    logic              hr_q, hr_qq;
    logic [7:0]        d_q;
    logic [7:0]        hi_q;
    logic              byte_phase;
    logic [PIX_W-1:0]  pix_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic [ADDR_W-1:0] line_base;

    logic vs_rise, vs_fall, hr_fall;
    logic pix_ok, line_ok;

    assign vs_rise = vs_q & ~vs_qq;
    assign vs_fall = ~vs_q & vs_qq;
    assign hr_fall = ~hr_q & hr_qq;
    assign pix_ok  = (pix_cnt < PIX_MAX);
    assign line_ok = (line_cnt < LINE_MAX);
    assign busy    = (state == S_ACTIVE);

    // RGB565 -> RGB444: keep the top bits of each channel.
    logic [3:0]  px_r, px_g, px_b;
    logic [11:0] px_data;
    logic        unused_bits;

    assign px_r        = hi_q[7:4];
    assign px_g        = {hi_q[2:0], d_q[7]};
    assign px_b        = d_q[4:1];
    assign unused_bits = ^{hi_q[3], d_q[6:5], d_q[0]};

`ifdef GRAYSCALE_EN
    logic [7:0] luma_sum;

    // Weights sum to 16, so the shifted result never exceeds 15.
    assign luma_sum = (8'd5 * {4'd0, px_r}) + (8'd9 * {4'd0, px_g}) + (8'd2 * {4'd0, px_b});
    assign px_data  = {luma_sum[7:4], luma_sum[7:4], luma_sum[7:4]};
`else
    assign px_data = {px_r, px_g, px_b};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_q  <= 1'b0;
            vs_qq <= 1'b0;
            hr_q  <= 1'b0;
            hr_qq <= 1'b0;
            d_q   <= 8'd0;
        end else begin
            vs_q  <= cam_vsync;
            vs_qq <= vs_q;
            hr_q  <= cam_href;
            hr_qq <= hr_q;
            d_q   <= cam_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            hi_q       <= 8'd0;
            byte_phase <= 1'b0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            line_base  <= '0;
            fb_we      <= 1'b0;
            fb_wAddr   <= '0;
            fb_wData   <= 12'd0;
            frame_done <= 1'b0;
        end else begin
            fb_we      <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (vs_rise && capture_en) begin
                        state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (vs_fall) begin
                        state      <= S_ACTIVE;
                        line_base  <= '0;
                        pix_cnt    <= '0;
                        line_cnt   <= '0;
                        byte_phase <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (vs_rise) begin
                        // A byte arriving with the VSYNC edge is dropped with the frame.
                        frame_done <= 1'b1;
                        byte_phase <= 1'b0;
                        state      <= capture_en ? S_ARMED : S_IDLE;
                    end else if (hr_q) begin
                        byte_phase <= ~byte_phase;
                        if (!byte_phase) begin
                            hi_q <= d_q;
                        end else begin
                            if (pix_ok && line_ok) begin
                                fb_we    <= 1'b1;
                                fb_wAddr <= line_base + ADDR_W'(pix_cnt);
                                fb_wData <= px_data;
                            end
                            if (pix_ok) begin
                                pix_cnt <= pix_cnt + PIX_W'(1);
                            end
                        end
                    end else if (hr_fall) begin
                        pix_cnt    <= '0;
                        byte_phase <= 1'b0;
                        if (line_ok) begin
                            line_base <= line_base + LINE_STEP;
                            line_cnt  <= line_cnt + LINE_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Self-checking bench for cam_frame_writer: directed reset/conversion/clamp/capture_en steps plus
// randomized frames compared against a per-pixel reference model of the frame-buffer writes.
module tb_cam_frame_writer;

    localparam int H  = 20;
    localparam int V  = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          capture_en;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_data;
    logic          fb_we;
    logic [AW-1:0] fb_wAddr;
    logic [11:0]   fb_wData;
    logic          frame_done;
    logic          busy;

    cam_frame_writer #(
        .H_PIX  (H),
        .V_LINES(V),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .capture_en(capture_en),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .fb_we     (fb_we),
        .fb_wAddr  (fb_wAddr),
        .fb_wData  (fb_wData),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Observations, written only by the monitor.
    logic [AW+11:0] obs_q[$];
    int done_cnt = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (fb_we) obs_q.push_back({fb_wAddr, fb_wData});
        if (frame_done) done_cnt++;
        if (busy) busy_cnt++;
    end

    // Reference model state.
    logic [AW+11:0] exp_q[$];
    logic [7:0]     lbuf[0:255];
    bit             armed = 0;
    bit             cap   = 0;
    int             line_idx = 0;
    int             obs_base = 0;
    int             done_base = 0;
    int             busy_base = 0;
    int             frame_start = 0;
    int             last_n = 0;
    int             last_addr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] conv(input logic [7:0] hi, input logic [7:0] lo);
        int r, g, b;
        r = int'(hi) / 16;
        g = (int'(hi) % 8) * 2 + int'(lo) / 128;
        b = (int'(lo) / 2) % 16;
`ifdef GRAYSCALE_EN
        return 12'(((5 * r + 9 * g + 2 * b) / 16) * 273);
`else
        return 12'(r * 256 + g * 16 + b);
`endif
    endfunction

    function automatic void model_px(input logic [7:0] hi, input logic [7:0] lo, input int pix);
        if (cap && line_idx < V && pix < H)
            exp_q.push_back({AW'(line_idx * H + pix), conv(hi, lo)});
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) lbuf[i] = 8'($urandom);
    endtask

    // Drives n bytes from lbuf; fin ends the line with HREF low. lat checks per-cycle latency.
    task automatic send_line(input int n, input bit lat, input bit fin);
        int k;
        int cyc;
        bit exp_we;
        cyc = fin ? n + 2 : n;
        for (int j = 0; j < cyc; j++) begin
            @(negedge clk);
            if (lat) begin
                k = j - 2;
                exp_we = (k >= 1) && (k < n) && (k % 2 == 1) && cap && (line_idx < V)
                         && (k / 2 < H);
                check("lat_we", fb_we, exp_we);
                if (exp_we) begin
                    check("lat_addr", fb_wAddr, line_idx * H + k / 2);
                    check("lat_data", fb_wData, conv(lbuf[k-1], lbuf[k]));
                end
            end
            if (j < n) begin
                cam_href = 1'b1;
                cam_data = lbuf[j];
                if (j % 2 == 1) model_px(lbuf[j-1], lbuf[j], j / 2);
            end else if (j == n) begin
                cam_href = 1'b0;
            end
        end
        if (fin) begin
            repeat (2) @(negedge clk);
            if (n > 0) line_idx++;
        end
    endtask

    task automatic vs_fall();
        @(negedge clk);
        cam_vsync = 1'b0;
        cap       = armed;
        armed     = 0;
        line_idx  = 0;
        repeat (4) @(negedge clk);
        check("busy_in_frame", busy, cap);
    endtask

    // Ends the frame and compares everything it wrote against the model.
    task automatic vs_rise(input bit next_en);
        int n;
        if (!cap) check("busy_uncaptured", busy_cnt - busy_base, 0);
        @(negedge clk);
        cam_vsync  = 1'b1;
        capture_en = next_en;
        armed      = armed | next_en;
        repeat (4) @(negedge clk);
        cam_href = 1'b0;
        n = obs_q.size() - obs_base;
        check("frame_wr_count", n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check("frame_wr", obs_q[obs_base+i], exp_q[i]);
        check("frame_done_cnt", done_cnt - done_base, cap ? 1 : 0);
        frame_start = obs_base;
        last_n      = n;
        if (n > 0) last_addr = int'(obs_q[obs_q.size()-1][AW+11:12]);
        exp_q.delete();
        obs_base  = obs_q.size();
        done_base = done_cnt;
        repeat (2) @(negedge clk);
        busy_base = busy_cnt;
    endtask

    initial begin
        int nl;
        int n;
        bit en;
        reset = 1'b1; capture_en = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_we", fb_we, 0);
        check("rst_addr", fb_wAddr, 0);
        check("rst_data", fb_wData, 0);
        check("rst_done", frame_done, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);
        vs_rise(1);

        // Conversion and latency on directed bytes.
        vs_fall();
        lbuf[0] = 8'hF8; lbuf[1] = 8'h00; lbuf[2] = 8'h07; lbuf[3] = 8'hE0;
        lbuf[4] = 8'h00; lbuf[5] = 8'h1F; lbuf[6] = 8'hFF; lbuf[7] = 8'hFF;
        send_line(8, 1, 1);
        fill_random(2 * H + 3);
        send_line(2 * H + 3, 1, 1);
        vs_rise(1);

        // Reset in the middle of a line; no writes until re-armed.
        vs_fall();
        fill_random(8);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = lbuf[j];
            if (j % 2 == 1 && j < 6) model_px(lbuf[j-1], lbuf[j], j / 2);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_we", fb_we, 0);
        check("midrst_addr", fb_wAddr, 0);
        check("midrst_data", fb_wData, 0);
        check("midrst_done", frame_done, 0);
        check("midrst_busy", busy, 0);
        cap   = 0;
        armed = 0;
        @(negedge clk);
        reset = 1'b0;
        busy_base = busy_cnt;
        fill_random(10);
        send_line(10, 0, 1);
        fill_random(2 * H);
        send_line(2 * H, 1, 1);
        vs_rise(1);

        // Full frame.
        vs_fall();
        for (int l = 0; l < V; l++) begin
            fill_random(2 * H);
            send_line(2 * H, 0, 1);
        end
        vs_rise(1);
        check("full_count", last_n, H * V);
        check("full_last_addr", last_addr, H * V - 1);

        // Over-long line, short odd line, then more lines than the frame holds.
        vs_fall();
        fill_random(2 * H + 40);
        send_line(2 * H + 40, 0, 1);
        fill_random(5);
        send_line(5, 1, 1);
        for (int l = 0; l < V + 1; l++) begin
            fill_random(2 * H);
            send_line(2 * H, 0, 1);
        end
        vs_rise(1);
        check("clamp_count", last_n, H + 2 + H * (V - 2));
        check("third_line_addr", int'(obs_q[frame_start+H+2][AW+11:12]), 2 * H);

        // Dropping capture_en mid-frame lets the frame finish, then capture stops.
        vs_fall();
        for (int l = 0; l < 4; l++) begin
            if (l == 2) capture_en = 1'b0;
            fill_random(2 * H);
            send_line(2 * H, 0, 1);
        end
        vs_rise(0);
        vs_fall();
        for (int l = 0; l < 2; l++) begin
            fill_random(2 * H);
            send_line(2 * H, 1, 1);
        end
        vs_rise(1);

        // Randomized frames, odd ones aborted by VSYNC mid-line.
        for (int f = 0; f < 6; f++) begin
            vs_fall();
            nl = $urandom_range(1, V + 2);
            for (int l = 0; l < nl; l++) begin
                n = $urandom_range(0, 2 * H + 6);
                fill_random(n);
                send_line(n, (l == 0), !((f % 2 == 1) && (l == nl - 1)));
            end
            en = ($urandom_range(0, 3) != 0);
            vs_rise(en);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
